// File: rtl/gmem_wr_burst_master.sv
// AXI-style write burst master: one AW per request, W beats streamed through, B responses tracked.
// Define GMEM_WR_BID_CHECK_EN to add an in-order ID FIFO that flags out-of-order B IDs on err.
module gmem_wr_burst_master #(
    parameter int MAX_OUTSTANDING = 4,
    parameter int BID_BASE        = 0,
    parameter int GMEM_ADDR_W     = 32,
    parameter int GMEM_DATA_W     = 32,
    parameter int ID_WIDTH        = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [GMEM_ADDR_W-1:0]     req_addr,
    input  logic [7:0]                 req_len,
    input  logic                       wd_valid,
    output logic                       wd_ready,
    input  logic [GMEM_DATA_W-1:0]     wd_data,
    input  logic [GMEM_DATA_W/8-1:0]   wd_strb,
    output logic [GMEM_ADDR_W-1:0]     m0_awaddr,
    output logic [7:0]                 m0_awlen,
    output logic                       m0_awvalid,
    input  logic                       m0_awready,
    output logic [ID_WIDTH-1:0]        m0_awid,
    output logic [GMEM_DATA_W-1:0]     m0_wdata,
    output logic [GMEM_DATA_W/8-1:0]   m0_wstrb,
    output logic                       m0_wlast,
    output logic                       m0_wvalid,
    input  logic                       m0_wready,
    input  logic                       m0_bvalid,
    output logic                       m0_bready,
    input  logic [ID_WIDTH-1:0]        m0_bid,
    output logic                       busy,
    output logic                       done,
    output logic [ID_WIDTH-1:0]        done_id,
    output logic                       err
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;
    localparam logic [CNT_W-1:0]    OUT_MAX  = CNT_W'(MAX_OUTSTANDING);
    localparam logic [ID_WIDTH-1:0] ID_FIRST = ID_WIDTH'(BID_BASE);
    localparam logic [ID_WIDTH-1:0] ID_LAST  = ID_WIDTH'(BID_BASE + MAX_OUTSTANDING - 1);

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t              state;
    logic [CNT_W-1:0]    outstanding;
    logic [ID_WIDTH-1:0] id_cnt;
    logic [7:0]          beat_cnt;
    logic                req_hs;
    logic                aw_hs;
    logic                w_hs;
    logic                b_hs;

`ifdef GMEM_WR_BID_CHECK_EN
    localparam int PTR_W = $clog2(MAX_OUTSTANDING);
    logic [ID_WIDTH-1:0] id_fifo [MAX_OUTSTANDING];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
`endif

    // Handshake-facing outputs are gated by rst so they read idle during the reset cycle itself.
    assign req_ready = !rst && (state == IDLE) && (outstanding < OUT_MAX);
    assign m0_wvalid = !rst && (state == DATA) && wd_valid;
    assign wd_ready  = !rst && (state == DATA) && m0_wready;
    assign m0_wlast  = !rst && (state == DATA) && (beat_cnt == 8'd0);
    assign busy      = !rst && ((state != IDLE) || (outstanding != '0));
    assign m0_wdata  = wd_data;
    assign m0_wstrb  = wd_strb;
    assign m0_bready = 1'b1;

    assign req_hs = req_valid && req_ready;
    assign aw_hs  = m0_awvalid && m0_awready;
    assign w_hs   = m0_wvalid && m0_wready;
    assign b_hs   = m0_bvalid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            outstanding <= '0;
            id_cnt      <= ID_FIRST;
            beat_cnt    <= '0;
            m0_awvalid  <= 1'b0;
            m0_awaddr   <= '0;
            m0_awlen    <= '0;
            m0_awid     <= '0;
            done        <= 1'b0;
            done_id     <= '0;
            err         <= 1'b0;
`ifdef GMEM_WR_BID_CHECK_EN
            wr_ptr      <= '0;
            rd_ptr      <= '0;
`endif
        end else begin
            done <= b_hs;
            if (b_hs)
                done_id <= m0_bid;

            case (state)
                IDLE: if (req_hs) begin
                    m0_awaddr  <= req_addr;
                    m0_awlen   <= req_len;
                    m0_awid    <= id_cnt;
                    m0_awvalid <= 1'b1;
                    state      <= ADDR;
                end
                ADDR: if (m0_awready) begin
                    m0_awvalid <= 1'b0;
                    beat_cnt   <= m0_awlen;
                    id_cnt     <= (id_cnt == ID_LAST) ? ID_FIRST : id_cnt + 1'b1;
                    state      <= DATA;
                end
                DATA: if (w_hs) begin
                    if (beat_cnt == 8'd0)
                        state <= IDLE;
                    else
                        beat_cnt <= beat_cnt - 1'b1;
                end
                default: state <= IDLE;
            endcase

            // A B response with nothing in flight is flagged and must not underflow the count.
            if (aw_hs && !b_hs)
                outstanding <= outstanding + 1'b1;
            else if (!aw_hs && b_hs && (outstanding != '0))
                outstanding <= outstanding - 1'b1;
            if (b_hs && (outstanding == '0))
                err <= 1'b1;

`ifdef GMEM_WR_BID_CHECK_EN
            if (aw_hs) begin
                id_fifo[wr_ptr] <= m0_awid;
                wr_ptr          <= wr_ptr + 1'b1;
            end
            if (b_hs && (outstanding != '0)) begin
                rd_ptr <= rd_ptr + 1'b1;
                if (m0_bid != id_fifo[rd_ptr])
                    err <= 1'b1;
            end
`endif
        end
    end

endmodule
